// File: rtl/reg_file_wb.sv
// reg_file_wb: parametrised register file and write-back stage with valid/ready writes,
// bypassed read ports, a per-register pending scoreboard and a multi-cycle clear sweep.
module reg_file_wb #(
    parameter int DATA_W    = 16,
    parameter int N_REGS    = 8,
    parameter int ADDR_W    = 3,
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic                     clk_wb,
    input  logic                     reset,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     clr,
    output logic                     clr_busy,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic [DATA_W-1:0]        rd_data_a,
    output logic [DATA_W-1:0]        rd_data_b,
    output logic                     rd_busy_a,
    output logic                     rd_busy_b,
    output logic [N_REGS*DATA_W-1:0] regs_flat
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_REGS - 1);
    localparam logic [ADDR_W:0]   NREGS = (ADDR_W + 1)'(N_REGS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic [N_REGS-1:0] pending_q, pending_d;
    logic              wb_fire, wb_we;

    assign wb_ready = state_q == IDLE;
    assign clr_busy = state_q == CLEAR;
    assign wb_fire  = wb_valid && wb_ready;
    // an accepted write only lands when it targets a real, writable register
    assign wb_we    = wb_fire && ({1'b0, wb_addr} < NREGS) && !(ZERO_REG0 && wb_addr == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == IDLE) begin
            state_d = clr ? CLEAR : IDLE;
            idx_d   = '0;
        end else begin
            state_d = idx_q == LAST ? IDLE : CLEAR;
            idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
        end
    end

    // issue is applied last so it wins over a same-cycle write or sweep
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_we && wb_addr == ADDR_W'(i)) begin
                regs_d[i]    = wb_data;
                pending_d[i] = 1'b0;
            end
            if (clr_busy && idx_q == ADDR_W'(i)) begin
                regs_d[i]    = '0;
                pending_d[i] = 1'b0;
            end
            if (issue_valid && issue_addr == ADDR_W'(i) && !(ZERO_REG0 && i == 0))
                pending_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_wb) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= '0;
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // out-of-range addresses match no register and so read 0 / not busy
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        rd_busy_a = 1'b0;
        rd_busy_b = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_data_a = regs_q[i];
                rd_busy_a = pending_q[i];
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_data_b = regs_q[i];
                rd_busy_b = pending_q[i];
            end
        end
        if (wb_we && wb_addr == rd_addr_a) begin
            rd_data_a = wb_data;
            rd_busy_a = 1'b0;
        end
        if (wb_we && wb_addr == rd_addr_b) begin
            rd_data_b = wb_data;
            rd_busy_b = 1'b0;
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: drives a default instance and a 6-register zero-reg0 instance with the
// same stimulus; directed vectors plus random traffic against an array-based model.
module tb_reg_file_wb;
    logic        clk_wb = 1'b0;
    logic        reset;
    logic        wb_valid, issue_valid, clr;
    logic [2:0]  wb_addr, issue_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wb_data;

    logic         ready0, busy0, rba0, rbb0, ready1, busy1, rba1, rbb1;
    logic [15:0]  rda0, rdb0, rda1, rdb1;
    logic [127:0] flat0;
    logic [95:0]  flat1;

    int checks = 0;
    int failures = 0;

    always #5 clk_wb = ~clk_wb;

    reg_file_wb dut0 (
        .clk_wb(clk_wb), .reset(reset), .wb_valid(wb_valid), .wb_ready(ready0),
        .wb_addr(wb_addr), .wb_data(wb_data), .issue_valid(issue_valid), .issue_addr(issue_addr),
        .clr(clr), .clr_busy(busy0), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda0), .rd_data_b(rdb0), .rd_busy_a(rba0), .rd_busy_b(rbb0), .regs_flat(flat0)
    );

    reg_file_wb #(.DATA_W(16), .N_REGS(6), .ADDR_W(3), .ZERO_REG0(1'b1)) dut1 (
        .clk_wb(clk_wb), .reset(reset), .wb_valid(wb_valid), .wb_ready(ready1),
        .wb_addr(wb_addr), .wb_data(wb_data), .issue_valid(issue_valid), .issue_addr(issue_addr),
        .clr(clr), .clr_busy(busy1), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda1), .rd_data_b(rdb1), .rd_busy_a(rba1), .rd_busy_b(rbb1), .regs_flat(flat1)
    );

    // reference model: register contents, pending bits, sweep position (-1 when idle)
    int          nr [2] = '{8, 6};
    bit          z0 [2] = '{1'b0, 1'b1};
    logic [15:0] mreg [2][8];
    bit          mpend [2][8];
    int          msw [2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit hard0(int d, logic [2:0] a);
        return z0[d] && a == 3'd0;
    endfunction

    function automatic bit m_we(int d);
        return wb_valid && msw[d] < 0 && int'(wb_addr) < nr[d] && !hard0(d, wb_addr);
    endfunction

    function automatic logic [15:0] exp_rd(int d, logic [2:0] a);
        if (int'(a) >= nr[d] || hard0(d, a)) return 16'h0;
        if (m_we(d) && wb_addr == a) return wb_data;
        return mreg[d][a];
    endfunction

    function automatic bit exp_busy(int d, logic [2:0] a);
        if (int'(a) >= nr[d] || hard0(d, a)) return 1'b0;
        return mpend[d][a] && !(m_we(d) && wb_addr == a);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            msw[d] = -1;
            for (int i = 0; i < 8; i++) begin
                mreg[d][i]  = 16'h0;
                mpend[d][i] = 1'b0;
            end
        end
    endtask

    task automatic model_update(input int d);
        bit w;
        w = m_we(d);
        if (w) begin
            mreg[d][wb_addr]  = wb_data;
            mpend[d][wb_addr] = 1'b0;
        end
        if (msw[d] >= 0) begin
            mreg[d][msw[d]]  = 16'h0;
            mpend[d][msw[d]] = 1'b0;
            msw[d] = msw[d] == nr[d] - 1 ? -1 : msw[d] + 1;
        end else if (clr) begin
            msw[d] = 0;
        end
        if (issue_valid && int'(issue_addr) < nr[d] && !hard0(d, issue_addr))
            mpend[d][issue_addr] = 1'b1;
    endtask

    task automatic compare(input int d);
        logic [127:0] ef;
        ef = '0;
        for (int i = 0; i < nr[d]; i++) ef[i*16 +: 16] = mreg[d][i];
        chk($sformatf("d%0d_wb_ready", d), d == 0 ? ready0 : ready1, msw[d] < 0);
        chk($sformatf("d%0d_clr_busy", d), d == 0 ? busy0 : busy1, msw[d] >= 0);
        chk($sformatf("d%0d_rd_data_a", d), d == 0 ? rda0 : rda1, exp_rd(d, rd_addr_a));
        chk($sformatf("d%0d_rd_data_b", d), d == 0 ? rdb0 : rdb1, exp_rd(d, rd_addr_b));
        chk($sformatf("d%0d_rd_busy_a", d), d == 0 ? rba0 : rba1, exp_busy(d, rd_addr_a));
        chk($sformatf("d%0d_rd_busy_b", d), d == 0 ? rbb0 : rbb1, exp_busy(d, rd_addr_b));
        chk($sformatf("d%0d_regs_flat", d), d == 0 ? flat0 : {32'h0, flat1}, ef);
    endtask

    // inputs are set at the falling edge; outputs compared just after, model advanced at the rising edge
    task automatic cycle(input bit do_chk = 1'b1);
        #1;
        if (do_chk) begin
            compare(0);
            compare(1);
        end
        @(posedge clk_wb);
        if (!reset) model_reset();
        else begin
            model_update(0);
            model_update(1);
        end
        @(negedge clk_wb);
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
        issue_valid = 1'b0; issue_addr = 3'd0; clr = 1'b0;
    endtask

    typedef struct {
        logic wv; logic [2:0] wa; logic [15:0] wd; logic iv; logic [2:0] ia;
        logic [2:0] ra; logic [2:0] rb;
        logic [15:0] era; logic eba; logic [15:0] erb; logic ebb;
    } vec_t;

    vec_t tbl [9];
    logic [95:0] saved1;
    int n;

    initial begin
        tbl[0] = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd3, 3'd5, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd5, 16'hBEEF, 1'b0, 16'h0000, 1'b1};
        tbl[3] = '{1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd3, 3'd5, 16'hBEEF, 1'b0, 16'h1234, 1'b0};
        tbl[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd5, 16'hBEEF, 1'b0, 16'h1234, 1'b0};
        tbl[5] = '{1'b1, 3'd2, 16'h7777, 1'b1, 3'd2, 3'd2, 3'd5, 16'h7777, 1'b0, 16'h1234, 1'b0};
        tbl[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd5, 16'h7777, 1'b1, 16'h1234, 1'b0};
        tbl[7] = '{1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 3'd2, 3'd5, 16'h0001, 1'b0, 16'h1234, 1'b0};
        tbl[8] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd5, 16'h0001, 1'b0, 16'h1234, 1'b0};

        model_reset();
        idle_inputs();
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        reset = 1'b0;
        @(negedge clk_wb);
        cycle(1'b0);
        reset = 1'b1;
        #1;
        chk("reset_wb_ready", ready0, 1'b1);
        chk("reset_clr_busy", busy0, 1'b0);
        chk("reset_regs_flat", flat0, 128'h0);

        for (int k = 0; k < 9; k++) begin
            wb_valid = tbl[k].wv; wb_addr = tbl[k].wa; wb_data = tbl[k].wd;
            issue_valid = tbl[k].iv; issue_addr = tbl[k].ia;
            rd_addr_a = tbl[k].ra; rd_addr_b = tbl[k].rb;
            #1;
            chk($sformatf("vec%0d_rd_data_a", k), rda0, tbl[k].era);
            chk($sformatf("vec%0d_rd_busy_a", k), rba0, tbl[k].eba);
            chk($sformatf("vec%0d_rd_data_b", k), rdb0, tbl[k].erb);
            chk($sformatf("vec%0d_rd_busy_b", k), rbb0, tbl[k].ebb);
            chk($sformatf("vec%0d_wb_ready", k), ready0, 1'b1);
            cycle();
        end
        idle_inputs();
        #1 chk("reg3_flat_beef", flat0[63:48], 16'hBEEF);

        // full sweep with a write to reg1 held until it is accepted
        for (int a = 0; a < 8; a++) begin
            wb_valid = 1'b1; wb_addr = 3'(a); wb_data = 16'hFFFF;
            cycle();
        end
        idle_inputs();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 16'h0055; rd_addr_a = 3'd1;
        n = 0;
        while (!ready0 && n < 20) begin
            #1;
            if (n < 8) chk($sformatf("sweep%0d_unswept", n), flat0[n*16 +: 16], 16'hFFFF);
            if (n > 0 && n < 9) chk($sformatf("sweep%0d_swept", n), flat0[(n-1)*16 +: 16], 16'h0);
            cycle();
            n++;
        end
        chk("sweep_len", n, 8);
        #1 chk("sweep_end_bypass", rda0, 16'h0055);
        cycle();
        idle_inputs();
        #1 chk("sweep_end_reg1", flat0[31:16], 16'h0055);

        // reset in the middle of a sweep
        for (int a = 0; a < 8; a++) begin
            wb_valid = 1'b1; wb_addr = 3'(a); wb_data = 16'hFFFF;
            cycle();
        end
        idle_inputs();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        #1;
        chk("midsweep_reg3", flat0[63:48], 16'h0);
        chk("midsweep_reg4", flat0[79:64], 16'hFFFF);
        chk("midsweep_busy", busy0, 1'b1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        #1;
        chk("midreset_flat", flat0, 128'h0);
        chk("midreset_busy", busy0, 1'b0);
        chk("midreset_ready", ready0, 1'b1);

        // 6-register instance: out-of-range address and hardwired register 0
        saved1 = flat1;
        wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 16'h1111; rd_addr_a = 3'd7;
        #1;
        chk("d1_oor_ready", ready1, 1'b1);
        chk("d1_oor_bypass", rda1, 16'h0);
        cycle();
        idle_inputs();
        #1;
        chk("d1_oor_flat", flat1, saved1);
        chk("d1_oor_read", rda1, 16'h0);
        wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 16'hAAAA; rd_addr_a = 3'd0;
        issue_valid = 1'b1; issue_addr = 3'd0;
        #1 chk("d1_r0_bypass", rda1, 16'h0);
        cycle();
        idle_inputs();
        #1;
        chk("d1_r0_read", rda1, 16'h0);
        chk("d1_r0_busy", rba1, 1'b0);
        chk("d0_r0_read", rda0, 16'hAAAA);
        chk("d0_r0_busy", rba0, 1'b1);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset       = $urandom_range(99) != 0;
            clr         = $urandom_range(24) == 0;
            wb_valid    = $urandom_range(1) == 1;
            wb_addr     = 3'($urandom_range(7));
            wb_data     = 16'($urandom);
            issue_valid = $urandom_range(2) == 0;
            issue_addr  = 3'($urandom_range(7));
            rd_addr_a   = 3'($urandom_range(7));
            rd_addr_b   = 3'($urandom_range(7));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
